instruction_rom_loader: RTL and testbench
=========================================

# instruction_rom_loader

Parametrised successor to the fixed-content 32K instruction ROM. Holds the CPU's program in a DEPTH x WIDTH array and serves instruction fetches, with a choice of combinational or registered read. Program contents are not hard-coded. They are streamed in at run time over a byte-wide valid/ready loader port, for example from a UART receiver. While a load is in progress, the block asserts `loading` so the CPU can be held.

## Interface
Parameters:
- WIDTH, 16: instruction width in bits; must be a multiple of 8.
- ADDR_W, 15: fetch address width.
- DEPTH, 2**ADDR_W: number of words.
- REG_READ, 0: 0 = combinational read; 1 = registered read with 1-cycle latency.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  CPU fetch address.
- out  out  WIDTH  instruction at `address`.
- load_start  in  1  start a load; sampled only in IDLE.
- load_len  in  ADDR_W+1  number of words to load, sampled with load_start.
- byte_in  in  8  loader data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  block accepts a byte this cycle.
- loading  out  1  load in progress; CPU must hold.
- load_done  out  1  one-cycle pulse when a load completes.
- words_loaded  out  ADDR_W+1  words written by the current or last load.

## Operation
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - load_start=1 latches len = min(load_len, DEPTH).
  - Clears words_loaded, write pointer and byte index.
  - Next state is RECV, or DONE if len=0.
- RECV:
  - byte_ready=1, loading=1.
  - A byte is accepted on each edge with byte_valid && byte_ready.
  - Bytes are assembled MSB-first: the first byte goes to [WIDTH-1:WIDTH-8].
  - Byte index counts 0..WIDTH/8-1.
  - On accepting the last byte of a word:
    - The word is written to the array at the write pointer.
    - The write pointer increments modulo DEPTH.
    - words_loaded increments.
  - When words_loaded reaches len, the next state is DONE.
- DONE: load_done=1, loading=1, byte_ready=0; next state is IDLE.
- load_start outside IDLE is ignored. Bytes presented outside RECV are not accepted.
- Fetch reads:
  - REG_READ=0: out = ARRAY[address] combinationally.
  - REG_READ=1: out registers ARRAY[address] each edge.
  - While loading=1, out is forced to 0 in both modes, i.e. Hack `@0`, which is harmless.
- Address bits beyond DEPTH: address is used modulo DEPTH.
- Array contents are not cleared by reset. An array with no load performed reads X in simulation.

## Timing
- Reset values:
  - byte_ready=0, loading=0, load_done=0, words_loaded=0.
  - out=0 when REG_READ=1; when REG_READ=0, out follows the array.
  - FSM is in IDLE.
- Load latency:
  - load_start sampled at edge N gives byte_ready=1 from cycle N+1.
  - Final byte accepted at edge M gives load_done=1 during cycle M+1 and loading=0 from M+2.
  - With len=0, load_done is high during cycle N+1.
- Throughput: one byte per cycle with byte_valid held high. A word takes WIDTH/8 cycles.
- Write-to-read:
  - REG_READ=0: a word written at edge M is visible on out combinationally after M, once loading drops.
  - REG_READ=1, same-edge collision: read-before-write.
- Reset mid-load:
  - Returns to IDLE next edge and clears the byte index, so the partial word is discarded.
  - Words already written stay in the array. words_loaded=0.

## Test plan
- Reset: assert reset 2 cycles -> loading=0, byte_ready=0, load_done=0, words_loaded=0; with REG_READ=1, out=0.
- Full program load:
  - Stimulus: load_len=24, then stream 48 bytes of the 3*4 multiply program, e.g. 0x00,0x03,0xEC,0x10,...
  - Required: load_done pulses exactly once, words_loaded=24, ROM[1] reads 0xEC10, ROM[21] reads 0xEA87, and out=0 throughout loading.
- Throttled stream: drop byte_valid every other cycle during a 4-word load -> identical array contents; byte_ready stays 1 through RECV.
- Boundaries:
  - load_len=0 -> load_done one cycle after start; nothing written.
  - load_len=DEPTH+5 -> clamped; after DEPTH words, load_done fires.
  - load_start asserted mid-load -> ignored.
- Reset mid-load: reset after 3 bytes of a 2-word load -> word 0 = loaded value, word 1 unchanged; a new load then starts cleanly at address 0.
- REG_READ=1 latency: address 0 -> 5 -> 21 on consecutive cycles -> out shows the corresponding words one cycle later each.

Source files
------------

// File: rtl/instruction_rom_loader.sv
// Instruction ROM whose program is streamed in at run time over a byte-wide valid/ready port.
// Bytes are assembled MSB-first into words; fetch reads return 0 while a load is in progress.
module instruction_rom_loader #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int REG_READ = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              loading,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  word_asm;
  logic [ADDR_W:0]   len_clamped;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;

  logic [WIDTH-1:0] mem [DEPTH];

  assign byte_ready   = (state_q == RECV);
  assign loading      = (state_q != IDLE);
  assign load_done    = (state_q == DONE);
  assign words_loaded = words_q;

  // Shifting the whole word left keeps the first byte of a word at the top.
  assign word_asm    = (shift_q << 8) | WIDTH'(byte_in);
  assign len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    wptr_d  = wptr_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          len_d   = len_clamped;
          words_d = '0;
          wptr_d  = '0;
          bidx_d  = '0;
          shift_d = '0;
          state_d = (len_clamped == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          shift_d = word_asm;
          if (bidx_q == LAST_BYTE) begin
            wr_en   = 1'b1;
            bidx_d  = '0;
            wptr_d  = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
            words_d = words_q + 1'b1;
            if (words_q + 1'b1 == len_q) state_d = DONE;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      words_q <= '0;
      wptr_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      wptr_q  <= wptr_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
    end
  end

  // Array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= word_asm;
  end

  generate
    if (DEPTH == 2**ADDR_W) begin : g_pow2
      assign rd_addr = address;
    end else begin : g_mod
      assign rd_addr = ADDR_W'(int'(address) % DEPTH);
    end

    if (REG_READ != 0) begin : g_reg_read
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (reset)        rd_q <= '0;
        else if (loading) rd_q <= '0;
        else              rd_q <= mem[rd_addr];
      end
      assign out = loading ? '0 : rd_q;
    end else begin : g_comb_read
      assign out = loading ? '0 : mem[rd_addr];
    end
  endgenerate

endmodule

// File: tb/tb_instruction_rom_loader.sv
// Self-checking bench: one combinational-read and one registered-read instance share all inputs;
// a software copy of the array drives a queue of expected read-back words.
module tb_instruction_rom_loader;

  localparam int AW = 5;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    byte_in;
  logic          byte_valid;

  logic [15:0]   out0, out1;
  logic          byte_ready, loading, load_done;
  logic [AW:0]   words_loaded;
  logic          byte_ready1, loading1, load_done1;
  logic [AW:0]   words_loaded1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model [DP];
  logic [15:0] src_q [$];
  logic [15:0] exp_q [$];

  logic [15:0] prog [24] = '{
    16'h0003, 16'hEC10, 16'h0010, 16'hE308, 16'h0004, 16'hEC10, 16'h0011, 16'hE308,
    16'h0002, 16'hEA88, 16'h0011, 16'hFC10, 16'h0016, 16'hE302, 16'h0010, 16'hFC10,
    16'h0002, 16'hF088, 16'h0011, 16'hFC98, 16'h000A, 16'hEA87, 16'h0016, 16'hEA87};

  instruction_rom_loader #(.WIDTH(16), .ADDR_W(AW), .DEPTH(DP), .REG_READ(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .out(out0),
    .load_start(load_start), .load_len(load_len), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .loading(loading), .load_done(load_done), .words_loaded(words_loaded));

  instruction_rom_loader #(.WIDTH(16), .ADDR_W(AW), .DEPTH(DP), .REG_READ(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .out(out1),
    .load_start(load_start), .load_len(load_len), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready1), .loading(loading1), .load_done(load_done1), .words_loaded(words_loaded1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams src_q through the handshake; the model array is updated from accepted bytes.
  task automatic run_load(input int len_req, input bit throttle, input bit poke, input int exp_words, input string tag);
    int nbytes;
    int bi;
    int cyc;
    int pulses;
    int wptr;
    bit out_bad;
    bit rdy_bad;
    bit timeout;
    bit valid;
    bit rdy;
    logic [15:0] w;
    nbytes = src_q.size() * 2;
    bi = 0; cyc = 0; pulses = 0; wptr = 0;
    out_bad = 0; rdy_bad = 0; timeout = 1;
    load_start = 1'b1;
    load_len = (AW+1)'(len_req);
    tick();
    load_start = 1'b0;
    while (cyc < 500) begin
      if (load_done === 1'b1) pulses++;
      if (loading !== 1'b1) begin
        timeout = 0;
        break;
      end
      if (out0 !== 16'h0 || out1 !== 16'h0) out_bad = 1;
      if (load_done !== 1'b1 && byte_ready !== 1'b1) rdy_bad = 1;
      valid = (bi < nbytes) && !(throttle && cyc[0]);
      w = (bi < nbytes) ? src_q[bi/2] : 16'h0;
      byte_in = (bi % 2 == 0) ? w[15:8] : w[7:0];
      byte_valid = valid;
      load_start = poke && (cyc == 2);
      if (poke && cyc == 2) load_len = (AW+1)'(1);
      rdy = byte_ready;
      tick();
      load_start = 1'b0;
      cyc++;
      if (valid && rdy) begin
        if (bi % 2 == 1) begin
          model[wptr] = src_q[bi/2];
          wptr = (wptr + 1) % DP;
        end
        bi++;
      end
    end
    byte_valid = 1'b0;
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL %s_timeout: loading still %b after %0d cycles, required 0", tag, loading, cyc); end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d required 1", tag, pulses); end
    n_checks++;
    if (out_bad) begin n_fail++; $display("FAIL %s_out_during_load: out nonzero while loading, required 0", tag); end
    n_checks++;
    if (rdy_bad) begin n_fail++; $display("FAIL %s_ready: byte_ready dropped during RECV, required 1", tag); end
    n_checks++;
    if (words_loaded !== (AW+1)'(exp_words)) begin n_fail++; $display("FAIL %s_words_loaded: got %0d required %0d", tag, words_loaded, exp_words); end
  endtask

  task automatic check_words(input int lo, input int hi, input string tag);
    logic [15:0] e;
    for (int a = lo; a <= hi; a++) begin
      address = AW'(a);
      exp_q.push_back(model[a]);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (out0 !== e) begin n_fail++; $display("FAIL %s_comb[%0d]: got %h required %h", tag, a, out0, e); end
      n_checks++;
      if (out1 !== e) begin n_fail++; $display("FAIL %s_reg[%0d]: got %h required %h", tag, a, out1, e); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; address = '0; load_start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (loading !== 1'b0) begin n_fail++; $display("FAIL reset_loading: got %b required 0", loading); end
    n_checks++;
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
    n_checks++;
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b required 0", load_done); end
    n_checks++;
    if (words_loaded !== '0) begin n_fail++; $display("FAIL reset_words_loaded: got %0d required 0", words_loaded); end
    n_checks++;
    if (out1 !== 16'h0) begin n_fail++; $display("FAIL reset_out_reg: got %h required 0000", out1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    src_q.delete();
    foreach (prog[i]) src_q.push_back(prog[i]);
    run_load(24, 0, 0, 24, "full");
    check_words(0, 23, "full");
    address = AW'(1);
    tick();
    n_checks++;
    if (out0 !== 16'hEC10) begin n_fail++; $display("FAIL full_rom1: got %h required ec10", out0); end
    address = AW'(21);
    tick();
    n_checks++;
    if (out1 !== 16'hEA87) begin n_fail++; $display("FAIL full_rom21: got %h required ea87", out1); end
  endtask

  task automatic test_reg_latency();
    address = AW'(0);
    tick();
    address = AW'(5);
    #1;
    n_checks++;
    if (out0 !== prog[5]) begin n_fail++; $display("FAIL lat_comb_immediate: got %h required %h", out0, prog[5]); end
    n_checks++;
    if (out1 !== prog[0]) begin n_fail++; $display("FAIL lat_reg_a0: got %h required %h", out1, prog[0]); end
    tick();
    address = AW'(21);
    #1;
    n_checks++;
    if (out1 !== prog[5]) begin n_fail++; $display("FAIL lat_reg_a5: got %h required %h", out1, prog[5]); end
    tick();
    n_checks++;
    if (out1 !== prog[21]) begin n_fail++; $display("FAIL lat_reg_a21: got %h required %h", out1, prog[21]); end
  endtask

  task automatic test_throttled();
    src_q = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001};
    run_load(4, 1, 0, 4, "throttle");
    check_words(0, 4, "throttle");
  endtask

  task automatic test_len_zero();
    load_start = 1'b1;
    load_len = '0;
    tick();
    load_start = 1'b0;
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b required 1", load_done); end
    n_checks++;
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL len0_ready: got %b required 0", byte_ready); end
    byte_in = 8'hFF;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    n_checks++;
    if (loading !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL len0_end: loading=%b load_done=%b required 0/0", loading, load_done); end
    n_checks++;
    if (words_loaded !== '0) begin n_fail++; $display("FAIL len0_words: got %0d required 0", words_loaded); end
    check_words(0, 1, "len0");
  endtask

  task automatic test_mid_start();
    src_q = '{16'h4242, 16'h9999};
    run_load(2, 0, 1, 2, "midstart");
    check_words(0, 2, "midstart");
  endtask

  task automatic test_clamp();
    src_q.delete();
    for (int i = 0; i < DP + 5; i++) src_q.push_back(16'(16'hC000 + i * 7));
    run_load(DP + 5, 0, 0, DP, "clamp");
    check_words(0, 3, "clamp");
    check_words(DP - 2, DP - 1, "clamp");
  endtask

  task automatic test_reset_midload();
    logic [7:0] bytes [3];
    bytes = '{8'hA1, 8'hB2, 8'hC3};
    load_start = 1'b1;
    load_len = (AW+1)'(2);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      byte_in = bytes[i];
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    model[0] = 16'hA1B2;
    reset = 1'b1;
    tick();
    n_checks++;
    if (loading !== 1'b0 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: loading=%b byte_ready=%b required 0/0", loading, byte_ready); end
    n_checks++;
    if (words_loaded !== '0) begin n_fail++; $display("FAIL rstmid_words: got %0d required 0", words_loaded); end
    tick();
    reset = 1'b0;
    check_words(0, 1, "rstmid");
    src_q = '{16'h5A5A};
    run_load(1, 0, 0, 1, "rstmid_reload");
    check_words(0, 1, "rstmid_reload");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reg_latency();
    test_throttled();
    test_len_zero();
    test_mid_start();
    test_clamp();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
